mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory/bus access port between two requesters: m0 is instruction fetch and m1 is load/store.
- Sits between the core's fetch/LSU and the bus decoder, for the multi-cycle core variant.
- Latches the winning command, drives the downstream port until the slave accepts it or a timeout expires, then returns data and status to the winner with a one-cycle done pulse.

Parameters:
- XLEN, 64, data/address width; byte-strobe width is XLEN/8.
- TIMEOUT, 16, maximum cycles s_en is held without s_ready before the access is aborted with an error (legal range 2..255).
- RR, 1, 1 = round-robin on simultaneous requests; 0 = fixed priority with m1 winning.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- m0_req  in  1  fetch request; held high until m0_done
- m0_addr  in  XLEN  fetch address (read only, full XLEN strobes implied)
- m0_rdata  out  XLEN  fetch data, valid when m0_done
- m0_done  out  1  one-cycle completion pulse
- m0_error  out  1  error status, valid with m0_done
- m1_req  in  1  data request; held high until m1_done
- m1_wr  in  1  1 = write
- m1_bytes  in  XLEN/8  byte strobes
- m1_addr  in  XLEN  data address
- m1_wdata  in  XLEN  write data
- m1_rdata  out  XLEN  read data, valid when m1_done
- m1_done  out  1  one-cycle completion pulse
- m1_error  out  1  error status, valid with m1_done
- s_en  out  1  downstream access enable
- s_wr  out  1  downstream write
- s_bytes  out  XLEN/8  downstream strobes
- s_addr  out  XLEN  downstream address
- s_wdata  out  XLEN  downstream write data
- s_rdata  in  XLEN  downstream read data, sampled when s_ready
- s_ready  in  1  slave accepts/completes the access this cycle
- s_error  in  1  slave error, sampled when s_ready
- busy  out  1  FSM not in IDLE
- grant  out  2  one-hot owner of the current transaction (00 in IDLE)

Behaviour:
- Interface: single clock clk, all state on posedge clk. rstn is asynchronous, active-low.
- Reset values: state IDLE, all outputs 0, last_grant = m1 (so m0 wins the first tie under RR=1), timeout counter 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select the winner.
  - Single requester wins.
  - Both high: if RR=1, the requester that did not own last_grant wins; if RR=0, m1 wins.
  - Latch the winner's wr/bytes/addr/wdata into command registers. For m0, wr=0 and bytes=all ones.
  - Set grant, clear the counter, go to ACCESS.
- ACCESS:
  - s_en=1 and s_* driven from the command registers, stable for the whole state.
  - s_ready=1: capture s_rdata and s_error into the response registers, go to RESP.
  - Otherwise counter+1. If the counter reaches TIMEOUT-1 without s_ready, set response error=1 and rdata=0, go to RESP.
- RESP:
  - s_en=0. Pulse the owner's mX_done for exactly this cycle with mX_rdata/mX_error from the response registers.
  - Update last_grant to the owner, clear grant, go to IDLE.
- Non-owner done is 0. Non-owner rdata/error hold their last values.
- Latency: req first seen at T, s_en at T+1. With s_ready at T+1, done is at T+2. Each stall cycle adds one. Minimum issue interval is 3 cycles per access.
- A request held through done is re-arbitrated in the following IDLE cycle. Requesters must drop req in the cycle after done unless a new access is intended.
- req withdrawn after IDLE latching: the transaction still completes and done is still pulsed.
- Timeout: exactly TIMEOUT cycles of s_en without s_ready, then RESP with error=1.
- s_ready arriving on the final timeout cycle counts as success.
- Inputs changing during ACCESS have no effect on s_*.
- Reset asserted mid-ACCESS or mid-RESP: immediate return to IDLE, s_en and done drop asynchronously, no done pulse is issued, last_grant returns to m1.

Test Plan:
- m0_req=1 at T, addr 0x8000_0000, s_ready=1 immediately, s_rdata=0x0000_0013 -> s_en=1 at T+1 with s_bytes=0xFF and s_wr=0; m0_done=1 at T+2 with m0_rdata=0x13 and m0_error=0.
- m0_req and m1_req both high from reset release, RR=1, s_ready always 1 -> grants alternate m0, m1, m0, m1; each done is spaced 3 cycles apart.
- Same stimulus with RR=0 -> m1 receives every grant while its req stays high; m0 is served only once m1_req drops.
- m1 write, addr 0x8000_0100, bytes 0x0F, wdata 0xDEAD_BEEF, s_ready delayed 4 cycles -> s_* stable for 5 cycles, m1_done 1 cycle after s_ready, m1_error=0.
- m1 read to an unmapped address, s_ready never asserted, TIMEOUT=16 -> s_en high 16 cycles, then m1_done with m1_error=1 and m1_rdata=0.
- rstn pulled low in the 2nd ACCESS cycle of an m0 fetch -> s_en, busy and grant go to 0 immediately; no m0_done; after release, a tie is granted to m0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter sharing one memory/bus access port
//
// Purpose: arbitrates between instruction fetch (m0) and load/store (m1), latches the
// winning command, holds it on the downstream port until s_ready or a timeout, then
// returns data/status to the winner with a one-cycle done pulse.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   m0_req/m0_addr                  fetch request (read, all strobes)
//   m0_rdata/m0_done/m0_error       fetch response
//   m1_req/m1_wr/m1_bytes/m1_addr/m1_wdata   load/store request
//   m1_rdata/m1_done/m1_error       load/store response
//   s_en/s_wr/s_bytes/s_addr/s_wdata          downstream command
//   s_rdata/s_ready/s_error         downstream response
//   busy                            FSM not idle
//   grant                           one-hot owner of current transaction

module mem_port_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 16,
  parameter int RR      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [XLEN-1:0]   m0_addr,
  output logic [XLEN-1:0]   m0_rdata,
  output logic              m0_done,
  output logic              m0_error,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [XLEN/8-1:0] m1_bytes,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              m1_done,
  output logic              m1_error,
  output logic              s_en,
  output logic              s_wr,
  output logic [XLEN/8-1:0] s_bytes,
  output logic [XLEN-1:0]   s_addr,
  output logic [XLEN-1:0]   s_wdata,
  input  logic [XLEN-1:0]   s_rdata,
  input  logic              s_ready,
  input  logic              s_error,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_last_m1;   // 1 = m1 owned the previous transaction
  logic            w_pick_m1;
  logic            w_finish;
  logic [XLEN-1:0] w_rsp_rdata;
  logic            w_rsp_err;

  // m1 wins when alone, or on a tie under fixed priority, or on a tie when m0 went last.
  assign w_pick_m1   = m1_req & (~m0_req | (RR == 0) | ~r_last_m1);

  // s_ready is checked before the counter so a response on the final cycle still succeeds.
  assign w_finish    = s_ready | (r_cnt == CNT_LAST);
  assign w_rsp_rdata = s_ready ? s_rdata : '0;
  assign w_rsp_err   = s_ready ? s_error : 1'b1;

  // The s_* command outputs are themselves the command registers: loaded once in IDLE,
  // untouched during ACCESS, so requester inputs cannot disturb an access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last_m1 <= 1'b1;
      m0_rdata  <= '0;
      m0_done   <= 1'b0;
      m0_error  <= 1'b0;
      m1_rdata  <= '0;
      m1_done   <= 1'b0;
      m1_error  <= 1'b0;
      s_en      <= 1'b0;
      s_wr      <= 1'b0;
      s_bytes   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      busy      <= 1'b0;
      grant     <= 2'b00;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant   <= w_pick_m1 ? 2'b10 : 2'b01;
            s_wr    <= w_pick_m1 ? m1_wr : 1'b0;
            s_bytes <= w_pick_m1 ? m1_bytes : '1;
            s_addr  <= w_pick_m1 ? m1_addr : m0_addr;
            s_wdata <= w_pick_m1 ? m1_wdata : '0;
            r_cnt   <= '0;
            s_en    <= 1'b1;
            busy    <= 1'b1;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (w_finish) begin
            s_en    <= 1'b0;
            r_state <= RESP;
            if (grant[1]) begin
              m1_done  <= 1'b1;
              m1_rdata <= w_rsp_rdata;
              m1_error <= w_rsp_err;
            end else begin
              m0_done  <= 1'b1;
              m0_rdata <= w_rsp_rdata;
              m0_error <= w_rsp_err;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_last_m1 <= grant[1];
          grant     <= 2'b00;
          busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter (RR=1 and RR=0 instances)

module tb_mem_port_arbiter;

  localparam int XLEN = 64;

  logic              clk = 1'b0;
  logic              rstn;
  logic              m0_req, m1_req, m1_wr, s_ready, s_error;
  logic [XLEN-1:0]   m0_addr, m1_addr, m1_wdata, s_rdata;
  logic [XLEN/8-1:0] m1_bytes;

  // round-robin instance outputs
  logic [XLEN-1:0]   m0_rdata, m1_rdata, s_addr, s_wdata;
  logic              m0_done, m0_error, m1_done, m1_error, s_en, s_wr, busy;
  logic [XLEN/8-1:0] s_bytes;
  logic [1:0]        grant;

  // fixed-priority instance outputs
  logic [XLEN-1:0]   b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
  logic              b_m0_done, b_m0_error, b_m1_done, b_m1_error, b_s_en, b_s_wr, b_busy;
  logic [XLEN/8-1:0] b_s_bytes;
  logic [1:0]        b_grant;

  typedef struct packed {
    logic [1:0]      owner;
    logic [XLEN-1:0] rdata;
    logic            err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(16), .RR(1)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_error(m0_error),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_bytes(m1_bytes), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_error(m1_error),
    .s_en(s_en), .s_wr(s_wr), .s_bytes(s_bytes), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_error(s_error),
    .busy(busy), .grant(grant)
  );

  mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(16), .RR(0)) u_fp (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdata(b_m0_rdata), .m0_done(b_m0_done), .m0_error(b_m0_error),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_bytes(m1_bytes), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_done(b_m1_done), .m1_error(b_m1_error),
    .s_en(b_s_en), .s_wr(b_s_wr), .s_bytes(b_s_bytes), .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_error(s_error),
    .busy(b_busy), .grant(b_grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] owner, input logic [XLEN-1:0] rdata, input logic err);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Response monitor for the round-robin instance: every done must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && (m0_done || m1_done)) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {62'd0, m1_done, m0_done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_owner", {62'd0, m1_done, m0_done}, {62'd0, e.owner});
        check("rsp_rdata", e.owner[1] ? m1_rdata : m0_rdata, e.rdata);
        check("rsp_error", {63'd0, e.owner[1] ? m1_error : m0_error}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; m0_req = 0; m1_req = 0; m1_wr = 0; s_ready = 0; s_error = 0;
    m0_addr = '0; m1_addr = '0; m1_wdata = '0; s_rdata = '0; m1_bytes = '0;
    #1;
    check("rst_s_en", {63'd0, s_en}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_grant", {62'd0, grant}, 64'd0);
    check("rst_done", {62'd0, m1_done, m0_done}, 64'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 64'd0);
    tick();
    tick();
    rstn = 1'b1;

    // Basic fetch with immediate ready: s_en at T+1, done at T+2.
    m0_req = 1; m0_addr = 64'h8000_0000; s_ready = 1; s_rdata = 64'h13;
    push(2'b01, 64'h13, 1'b0);
    tick();
    check("f_s_en", {63'd0, s_en}, 64'd1);
    check("f_s_bytes", {56'd0, s_bytes}, 64'hFF);
    check("f_s_wr", {63'd0, s_wr}, 64'd0);
    check("f_s_addr", s_addr, 64'h8000_0000);
    check("f_grant", {62'd0, grant}, 64'd1);
    check("f_busy", {63'd0, busy}, 64'd1);
    check("f_early_done", {63'd0, m0_done}, 64'd0);
    tick();
    check("f_done", {63'd0, m0_done}, 64'd1);
    check("f_resp_s_en", {63'd0, s_en}, 64'd0);
    m0_req = 0;
    tick();
    check("f_idle_busy", {63'd0, busy}, 64'd0);
    check("f_idle_grant", {62'd0, grant}, 64'd0);
    check("f_done_pulse", {63'd0, m0_done}, 64'd0);

    // Simultaneous requests from reset release: RR alternates, fixed priority keeps m1.
    do_reset();
    m0_req = 1; m1_req = 1; m1_wr = 0; m1_addr = 64'h100; s_ready = 1; s_rdata = 64'h55;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      push(exp_g, 64'h55, 1'b0);
      tick();
      check("rr_grant", {62'd0, grant}, {62'd0, exp_g});
      check("fp_grant", {62'd0, b_grant}, 64'd2);
      tick();
      check("rr_done", {62'd0, m1_done, m0_done}, {62'd0, exp_g});
      check("fp_done", {62'd0, b_m1_done, b_m0_done}, 64'd2);
      tick();
    end
    m1_req = 0;
    push(2'b01, 64'h55, 1'b0);
    tick();
    check("rr_grant_m0", {62'd0, grant}, 64'd1);
    check("fp_grant_m0", {62'd0, b_grant}, 64'd1);
    tick();
    m0_req = 0;
    tick();

    // Slave error captured with ready.
    m0_req = 1; m0_addr = 64'h8000_0008; s_ready = 1; s_rdata = 64'hABCD; s_error = 1;
    push(2'b01, 64'hABCD, 1'b1);
    tick();
    tick();
    m0_req = 0; s_error = 0;
    tick();

    // Stalled write: command stable for 5 cycles despite input changes and req withdrawal.
    m1_req = 1; m1_wr = 1; m1_bytes = 8'h0F; m1_addr = 64'h8000_0100; m1_wdata = 64'hDEAD_BEEF;
    s_ready = 0; s_rdata = 64'h1234;
    push(2'b10, 64'h1234, 1'b0);
    tick();
    m1_req = 0; m1_wr = 0; m1_bytes = 8'hFF; m1_addr = '0; m1_wdata = '0;
    for (int c = 1; c <= 5; c++) begin
      check("w_s_en", {63'd0, s_en}, 64'd1);
      check("w_s_wr", {63'd0, s_wr}, 64'd1);
      check("w_s_bytes", {56'd0, s_bytes}, 64'h0F);
      check("w_s_addr", s_addr, 64'h8000_0100);
      check("w_s_wdata", s_wdata, 64'hDEAD_BEEF);
      check("w_early_done", {63'd0, m1_done}, 64'd0);
      if (c == 5) s_ready = 1;
      tick();
    end
    check("w_done", {63'd0, m1_done}, 64'd1);
    check("w_resp_s_en", {63'd0, s_en}, 64'd0);
    s_ready = 0;
    tick();

    // Timeout: exactly 16 cycles of s_en, then error with zero data.
    m1_req = 1; m1_wr = 0; m1_addr = 64'hF000_0000;
    push(2'b10, 64'd0, 1'b1);
    tick();
    m1_req = 0;
    for (int c = 1; c <= 16; c++) begin
      check("to_s_en", {63'd0, s_en}, 64'd1);
      tick();
    end
    check("to_done", {63'd0, m1_done}, 64'd1);
    check("to_s_en_drop", {63'd0, s_en}, 64'd0);
    check("to_m0_no_done", {63'd0, m0_done}, 64'd0);
    check("to_m0_hold", m0_rdata, 64'hABCD);
    check("to_m0_err_hold", {63'd0, m0_error}, 64'd1);
    tick();

    // Ready on the final timeout cycle counts as success.
    m1_req = 1;
    push(2'b10, 64'h77, 1'b0);
    tick();
    m1_req = 0;
    for (int c = 1; c <= 16; c++) begin
      check("lt_s_en", {63'd0, s_en}, 64'd1);
      if (c == 16) begin
        s_ready = 1;
        s_rdata = 64'h77;
      end
      tick();
    end
    check("lt_done", {63'd0, m1_done}, 64'd1);
    s_ready = 0;
    tick();

    // Reset in the second ACCESS cycle of a fetch: outputs drop at once, no done.
    m0_req = 1; m0_addr = 64'h8000_0000;
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("ra_s_en", {63'd0, s_en}, 64'd0);
    check("ra_busy", {63'd0, busy}, 64'd0);
    check("ra_grant", {62'd0, grant}, 64'd0);
    check("ra_done", {63'd0, m0_done}, 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    m1_req = 1; s_ready = 1; s_rdata = 64'h99;
    push(2'b01, 64'h99, 1'b0);
    tick();
    check("ra_tie_grant", {62'd0, grant}, 64'd1);
    m0_req = 0; m1_req = 0;
    tick();
    check("ra_tie_done", {63'd0, m0_done}, 64'd1);
    s_ready = 0;
    repeat (4) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
